// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bus between the core's memory stage and
// the data-memory responder.
//   master modport: core side; drives requests, consumes responses.
//   slave  modport: memory side; accepts requests, produces responses.
// Signals:
//   req_valid/req_ready   request handshake
//   req_write             1 = store, 0 = load
//   req_addr              byte address (DM_ADDRESS bits)
//   req_wdata             store data
//   req_funct3            RISC-V access size / signedness
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             extended load data (0 for stores and errors)
//   rsp_err               illegal funct3 or misaligned access
interface dmem_responder_if #(
   parameter int unsigned DM_ADDRESS = 9,
   parameter int unsigned DATA_W     = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [DM_ADDRESS-1:0] req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [2:0]            req_funct3;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_funct3, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder. Accepts one load/store at a
// time, waits LATENCY cycles, then returns load data or a store acknowledge.
// Applies RISC-V funct3 sizing with sign/zero extension, little-endian.
// Ports:
//   clk    clock, all state updates on the rising edge
//   reset  synchronous active-low reset
//   bus    dmem_responder_if.slave request/response handshakes
//   busy   high while a transaction is in WAIT or RESP
// Build option:
//   DMEM_ALIGN_CHECK_EN  misaligned halfword/word accesses return rsp_err; when
//                        undefined they are truncated to natural alignment.
module dmem_responder #(
   parameter int unsigned DM_ADDRESS = 9,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned LATENCY    = 2
) (
   input  logic              clk,
   input  logic              reset,
   dmem_responder_if.slave   bus,
   output logic              busy
);

   localparam int unsigned Words = 2 ** (DM_ADDRESS - 2);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e                state_q;
   logic [3:0]            cnt_q;
   logic                  wr_q;
   logic [DM_ADDRESS-1:0] addr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [2:0]            f3_q;
   logic                  req_ready_q;
   logic                  rsp_valid_q;
   logic                  rsp_err_q;
   logic                  busy_q;
   logic [DATA_W-1:0]     rsp_rdata_q;
   logic [DATA_W-1:0]     mem_q [Words];

   logic                  cur_write;
   logic [DM_ADDRESS-1:0] cur_addr;
   logic [DATA_W-1:0]     cur_wdata;
   logic [2:0]            cur_f3;
   logic                  commit;
   logic                  f3_legal;
   logic                  access_err;
   logic [DM_ADDRESS-3:0] word_idx;
   logic [DATA_W-1:0]     rd_word;
   logic [7:0]            byte_val;
   logic [15:0]           half_val;
   logic [DATA_W-1:0]     load_data;
   logic [DATA_W-1:0]     wr_word;
`ifdef DMEM_ALIGN_CHECK_EN
   logic                  misalign;
`endif

   // In IDLE the live request is used so that LATENCY==1 can commit on the
   // accept edge; afterwards the latched copy drives the access.
   always_comb begin
      cur_write = wr_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_f3    = f3_q;
      if (state_q == StIdle) begin
         cur_write = bus.req_write;
         cur_addr  = bus.req_addr;
         cur_wdata = bus.req_wdata;
         cur_f3    = bus.req_funct3;
      end
   end

   // Commit happens on the edge that enters RESP.
   assign commit = ((state_q == StIdle) && bus.req_valid && (LATENCY == 1)) ||
                   ((state_q == StWait) && (cnt_q == 4'd1));

   always_comb begin
      if (cur_write) begin
         f3_legal = (cur_f3 == 3'b000) || (cur_f3 == 3'b001) || (cur_f3 == 3'b010);
      end else begin
         f3_legal = (cur_f3 == 3'b000) || (cur_f3 == 3'b001) || (cur_f3 == 3'b010) ||
                    (cur_f3 == 3'b100) || (cur_f3 == 3'b101);
      end
`ifdef DMEM_ALIGN_CHECK_EN
      misalign   = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                   ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
      access_err = !f3_legal || misalign;
`else
      access_err = !f3_legal;
`endif
   end

   // Word index ignores addr[1:0], which also gives the truncating behaviour
   // for misaligned words; halfword lane uses addr[1] only.
   always_comb begin
      word_idx = cur_addr[DM_ADDRESS-1:2];
      rd_word  = mem_q[word_idx];
      byte_val = rd_word[{cur_addr[1:0], 3'b000} +: 8];
      half_val = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

      case (cur_f3)
         3'b000:  load_data = {{24{byte_val[7]}}, byte_val};
         3'b001:  load_data = {{16{half_val[15]}}, half_val};
         3'b010:  load_data = rd_word;
         3'b100:  load_data = {24'd0, byte_val};
         3'b101:  load_data = {16'd0, half_val};
         default: load_data = '0;
      endcase

      wr_word = rd_word;
      case (cur_f3[1:0])
         2'b00: wr_word[{cur_addr[1:0], 3'b000} +: 8] = cur_wdata[7:0];
         2'b01: begin
            if (cur_addr[1]) wr_word[31:16] = cur_wdata[15:0];
            else             wr_word[15:0]  = cur_wdata[15:0];
         end
         2'b10:   wr_word = cur_wdata;
         default: wr_word = rd_word;
      endcase
   end

   // Array is never cleared; a reset on the commit edge suppresses the write.
   always_ff @(posedge clk) begin
      if (reset && commit && cur_write && !access_err) begin
         mem_q[word_idx] <= wr_word;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.req_valid) begin
                  wr_q        <= bus.req_write;
                  addr_q      <= bus.req_addr;
                  wdata_q     <= bus.req_wdata;
                  f3_q        <= bus.req_funct3;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= StWait;
                  cnt_q       <= 4'(LATENCY - 1);
               end
            end
            StWait: cnt_q <= cnt_q - 4'd1;
            StResp: begin
               if (bus.rsp_ready) begin
                  state_q     <= StIdle;
                  req_ready_q <= 1'b1;
                  rsp_valid_q <= 1'b0;
                  rsp_rdata_q <= '0;
                  rsp_err_q   <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
         // Overrides the WAIT entry above when the access commits right away.
         if (commit) begin
            state_q     <= StResp;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= access_err;
            rsp_rdata_q <= (cur_write || access_err) ? '0 : load_data;
         end
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int unsigned LATENCY = 2;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk;
   logic reset;
   logic busy;
   int   total;
   int   bad;
   exp_t sb_q[$];

   dmem_responder_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

   dmem_responder #(
      .DM_ADDRESS(9),
      .DATA_W    (32),
      .LATENCY   (LATENCY)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one request, pushes its expectation, waits (bounded) for the
   // response and completes the handshake if rsp_ready is high.
   task automatic run_req(input logic w, input logic [8:0] a, input logic [31:0] d,
                          input logic [2:0] f3, input logic [31:0] exp_rd,
                          input logic exp_err, output logic [31:0] rd, output logic err,
                          output int lat);
      logic done;
      sb_q.push_back('{rdata: exp_rd, err: exp_err});
      bus.req_valid  = 1'b1;
      bus.req_write  = w;
      bus.req_addr   = a;
      bus.req_wdata  = d;
      bus.req_funct3 = f3;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      lat  = 99;
      done = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         if (!done) begin
            if (bus.rsp_valid === 1'b1) begin
               lat  = i;
               done = 1'b1;
            end else begin
               @(posedge clk);
               #1;
            end
         end
      end
      rd  = bus.rsp_rdata;
      err = bus.rsp_err;
      if (done && bus.rsp_ready) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      total += 5;
      if (bus.req_ready !== 1'b1) begin
         bad++; $display("FAIL reset_req_ready got=%b want=1", bus.req_ready);
      end
      if (bus.rsp_valid !== 1'b0) begin
         bad++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid);
      end
      if (busy !== 1'b0) begin
         bad++; $display("FAIL reset_busy got=%b want=0", busy);
      end
      if (bus.rsp_err !== 1'b0) begin
         bad++; $display("FAIL reset_rsp_err got=%b want=0", bus.rsp_err);
      end
      if (bus.rsp_rdata !== 32'h0) begin
         bad++; $display("FAIL reset_rsp_rdata got=%h want=0", bus.rsp_rdata);
      end
   endtask

   task automatic test_store_load();
      logic [31:0] rd;
      logic        err;
      int          lat;
      exp_t        e;
      run_req(1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, rd, err, lat);
      e = sb_q.pop_front();
      total += 3;
      if (lat !== LATENCY) begin
         bad++; $display("FAIL sw_latency got=%0d want=%0d", lat, LATENCY);
      end
      if (rd !== e.rdata) begin
         bad++; $display("FAIL sw_rdata got=%h want=%h", rd, e.rdata);
      end
      if (err !== e.err) begin
         bad++; $display("FAIL sw_err got=%b want=%b", err, e.err);
      end
      total++;
      if (bus.req_ready !== 1'b1) begin
         bad++; $display("FAIL sw_ready_after got=%b want=1", bus.req_ready);
      end
      run_req(1'b0, 9'h010, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, rd, err, lat);
      e = sb_q.pop_front();
      total += 3;
      if (lat !== LATENCY) begin
         bad++; $display("FAIL lw_latency got=%0d want=%0d", lat, LATENCY);
      end
      if (rd !== e.rdata) begin
         bad++; $display("FAIL lw_rdata got=%h want=%h", rd, e.rdata);
      end
      if (err !== e.err) begin
         bad++; $display("FAIL lw_err got=%b want=%b", err, e.err);
      end
   endtask

   task automatic test_subword_loads();
      logic [8:0]  addr_t [7] = '{9'h013, 9'h013, 9'h012, 9'h010, 9'h011, 9'h010, 9'h010};
      logic [2:0]  f3_t   [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b100};
      logic [31:0] exp_t_ [7] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF,
                                  32'hFFFFFFBE, 32'hFFFFBEEF, 32'h000000EF};
      logic [31:0] rd;
      logic        err;
      int          lat;
      exp_t        e;
      for (int i = 0; i < 7; i++) begin
         run_req(1'b0, addr_t[i], 32'h0, f3_t[i], exp_t_[i], 1'b0, rd, err, lat);
         e = sb_q.pop_front();
         total += 2;
         if (rd !== e.rdata || lat !== LATENCY) begin
            bad++;
            $display("FAIL subword_load[%0d] got=%h lat=%0d want=%h lat=%0d", i, rd, lat,
                     e.rdata, LATENCY);
         end
         if (err !== e.err) begin
            bad++; $display("FAIL subword_err[%0d] got=%b want=%b", i, err, e.err);
         end
      end
   endtask

   task automatic test_partial_store();
      logic [31:0] rd;
      logic        err;
      int          lat;
      exp_t        e;
      run_req(1'b1, 9'h011, 32'hFFFFFF55, 3'b000, 32'h0, 1'b0, rd, err, lat);
      e = sb_q.pop_front();
      total++;
      if (rd !== e.rdata || err !== e.err) begin
         bad++; $display("FAIL sb_ack got=%h/%b want=%h/%b", rd, err, e.rdata, e.err);
      end
      run_req(1'b0, 9'h010, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0, rd, err, lat);
      e = sb_q.pop_front();
      total++;
      if (rd !== e.rdata || err !== e.err) begin
         bad++; $display("FAIL sb_readback got=%h/%b want=%h/%b", rd, err, e.rdata, e.err);
      end
      // Halfword store into the upper lane of a fresh word.
      run_req(1'b1, 9'h030, 32'h11223344, 3'b010, 32'h0, 1'b0, rd, err, lat);
      void'(sb_q.pop_front());
      run_req(1'b1, 9'h032, 32'hFFFFA5A5, 3'b001, 32'h0, 1'b0, rd, err, lat);
      void'(sb_q.pop_front());
      run_req(1'b0, 9'h030, 32'h0, 3'b010, 32'hA5A53344, 1'b0, rd, err, lat);
      e = sb_q.pop_front();
      total++;
      if (rd !== e.rdata) begin
         bad++; $display("FAIL sh_readback got=%h want=%h", rd, e.rdata);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd;
      logic        err;
      int          lat;
      exp_t        e;
      bus.rsp_ready = 1'b0;
      run_req(1'b0, 9'h010, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0, rd, err, lat);
      e = sb_q.pop_front();
      total++;
      if (rd !== e.rdata || lat !== LATENCY) begin
         bad++; $display("FAIL bp_first got=%h lat=%0d want=%h", rd, lat, e.rdata);
      end
      // A competing store is presented while the response is stalled.
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_addr   = 9'h010;
      bus.req_wdata  = 32'h0BADF00D;
      bus.req_funct3 = 3'b010;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.req_ready !== 1'b0 ||
             busy !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold[%0d] got v=%b d=%h rdy=%b busy=%b want v=1 d=%h rdy=0 busy=1",
                     i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, busy, e.rdata);
         end
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         bad++; $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", bus.rsp_valid,
                         bus.req_ready);
      end
      run_req(1'b0, 9'h010, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0, rd, err, lat);
      e = sb_q.pop_front();
      total++;
      if (rd !== e.rdata) begin
         bad++; $display("FAIL bp_ignored_store got=%h want=%h", rd, e.rdata);
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd;
      logic        err;
      int          lat;
      exp_t        e;
      run_req(1'b0, 9'h010, 32'h0, 3'b011, 32'h0, 1'b1, rd, err, lat);
      e = sb_q.pop_front();
      total++;
      if (rd !== e.rdata || err !== e.err) begin
         bad++; $display("FAIL bad_f3_load got=%h/%b want=%h/%b", rd, err, e.rdata, e.err);
      end
      run_req(1'b1, 9'h010, 32'h77777777, 3'b100, 32'h0, 1'b1, rd, err, lat);
      e = sb_q.pop_front();
      total++;
      if (rd !== e.rdata || err !== e.err) begin
         bad++; $display("FAIL bad_f3_store got=%h/%b want=%h/%b", rd, err, e.rdata, e.err);
      end
`ifdef DMEM_ALIGN_CHECK_EN
      run_req(1'b0, 9'h012, 32'h0, 3'b010, 32'h0, 1'b1, rd, err, lat);
`else
      run_req(1'b0, 9'h012, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0, rd, err, lat);
`endif
      e = sb_q.pop_front();
      total++;
      if (rd !== e.rdata || err !== e.err) begin
         bad++; $display("FAIL misaligned_lw got=%h/%b want=%h/%b", rd, err, e.rdata, e.err);
      end
      run_req(1'b0, 9'h010, 32'h0, 3'b010, 32'hDEAD55EF, 1'b0, rd, err, lat);
      e = sb_q.pop_front();
      total++;
      if (rd !== e.rdata || err !== e.err) begin
         bad++; $display("FAIL err_no_write got=%h/%b want=%h/%b", rd, err, e.rdata, e.err);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic        err;
      int          lat;
      exp_t        e;
      run_req(1'b1, 9'h020, 32'hA5A5A5A5, 3'b010, 32'h0, 1'b0, rd, err, lat);
      void'(sb_q.pop_front());
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_addr   = 9'h020;
      bus.req_wdata  = 32'h12345678;
      bus.req_funct3 = 3'b010;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      total++;
      if (busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         bad++; $display("FAIL mid_wait got busy=%b v=%b want busy=1 v=0", busy, bus.rsp_valid);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      total++;
      if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         bad++; $display("FAIL mid_reset got busy=%b v=%b rdy=%b want 0/0/1", busy,
                         bus.rsp_valid, bus.req_ready);
      end
      @(posedge clk);
      #1;
      run_req(1'b0, 9'h020, 32'h0, 3'b010, 32'hA5A5A5A5, 1'b0, rd, err, lat);
      e = sb_q.pop_front();
      total++;
      if (rd !== e.rdata) begin
         bad++; $display("FAIL mid_reset_store_dropped got=%h want=%h", rd, e.rdata);
      end
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      reset          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.req_funct3 = '0;
      bus.rsp_ready  = 1'b1;
      test_reset();
      test_store_load();
      test_subword_loads();
      test_partial_store();
      test_backpressure();
      test_errors();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the pipeline's data-memory port. It accepts one load or store request at a time over a valid/ready handshake, waits a programmable access latency, then returns the load data or store acknowledge over a second valid/ready handshake. It applies RISC-V funct3 sizing and sign/zero extension, little-endian, and lets the core's memory stage be verified against a multi-cycle memory instead of the single-cycle array.

Parameters:
DM_ADDRESS, 9, byte-address width; array holds 2^(DM_ADDRESS-2) 32-bit words.
DATA_W, 32, data width; fixed at 32.
LATENCY, 2, cycles from the request-accept edge to rsp_valid rising; legal range 1..15.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
req_valid  in  1  request present.
req_ready  out  1  responder can accept a request (high only in IDLE).
req_write  in  1  1 = store, 0 = load.
req_addr  in  DM_ADDRESS  byte address.
req_wdata  in  DATA_W  store data; the low bytes are used for SB and SH.
req_funct3  in  3  access size and signedness, RISC-V encoding.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer takes the response.
rsp_rdata  out  DATA_W  extended load data; 0 for stores and for errors.
rsp_err  out  1  illegal funct3 or misaligned access; qualified by rsp_valid.
busy  out  1  high in WAIT or RESP.

Behaviour:
- Reset (reset==0 at a clock edge): state goes to IDLE, latency counter = 0.
  - Output reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - Array contents are not cleared.
  - Reset mid-transaction drops the transaction. A store not yet committed is never written.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. When req_valid=1, latch write, addr, wdata and funct3. If LATENCY==1 go to RESP; otherwise go to WAIT with counter=LATENCY-1.
  - WAIT: decrement the counter each cycle. When the counter reaches 1, go to RESP on the next edge.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_ready=1, then go to IDLE.
  - Net timing: rsp_valid rises exactly LATENCY cycles after the accept edge.
- Commit point: the edge that enters RESP.
  - Loads sample the array and stores write the array on this edge.
  - A load issued after a store therefore sees the stored data.
- Accepted funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code: rsp_err=1, no array access, rsp_rdata=0.
- Lane selection: byte lane = addr[1:0]; halfword lane = addr[1]; word index = addr[DM_ADDRESS-1:2].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - SB/SH update only the selected bytes; the other bytes of the word are unchanged.
- No request pipelining: a new request is accepted no earlier than the cycle after the RESP handshake completes.
- If rsp_ready is already high on the first RESP cycle, the handshake completes that cycle, giving a LATENCY+1 cycle turnaround.
- req_* signals are ignored outside IDLE.

Optional Feature:
DMEM_ALIGN_CHECK_EN
- Defined: a halfword with addr[0]=1 or a word with addr[1:0]!=0 returns rsp_err=1 and rsp_rdata=0, and the array is not modified.
- Undefined: misaligned addresses are truncated to the natural alignment (halfword clears addr[0]; word clears addr[1:0]) and the access proceeds. rsp_err reports only illegal funct3.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release -> req_ready=1, rsp_valid=0, busy=0, rsp_err=0.
- SW then LW, LATENCY=2, rsp_ready held high:
  - SW addr=0x010, wdata=0xDEADBEEF.
  - Then LW addr=0x010 -> rsp_rdata=0xDEADBEEF.
  - Each rsp_valid appears exactly 2 cycles after its accept.
- Byte and halfword loads after the SW to 0x010:
  - LB 0x013 -> 0xFFFFFFDE.
  - LBU 0x013 -> 0x000000DE.
  - LH 0x012 -> 0xFFFFDEAD.
  - LHU 0x010 -> 0x0000BEEF.
- Partial stores and backpressure:
  - SB addr=0x011, wdata=0x55, then LW 0x010 -> 0xDEAD55EF.
  - Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable, req_ready=0, and a second req_valid is ignored.
- Errors:
  - funct3=011 load -> rsp_err=1, rsp_rdata=0.
  - With DMEM_ALIGN_CHECK_EN, LW 0x012 -> rsp_err=1.
  - Without it, LW 0x012 -> 0xDEAD55EF, rsp_err=0.
- Reset mid-operation: accept SW 0x020=0x12345678, then assert reset in WAIT -> a later LW 0x020 returns the prior contents, not 0x12345678.
